accu_frame_tx: RTL

//  Transmit side of the 8-bit valid/ready byte stream consumed by the XOR accumulator.

---
 rtl/accu_frame_tx.sv | 105 ++++++++++
 1 files changed

// File: rtl/accu_frame_tx.sv
// Frame serialiser: parallel frame in, LSB-byte-first valid/ready byte stream out.
// Define ACCU_TX_CSUM_APPEND_EN to append the running XOR checksum as an extra beat.
module accu_frame_tx #(
    parameter int DATA_W = 8,
    parameter int BEATS  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W*BEATS-1:0]   frame_data,
    input  logic                      frame_valid,
    output logic                      frame_ready,
    output logic [DATA_W-1:0]         data_out,
    output logic                      valid_a,
    input  logic                      ready_a,
    output logic                      last_a,
    output logic [DATA_W-1:0]         csum_out,
    output logic                      csum_valid
);

    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

`ifdef ACCU_TX_CSUM_APPEND_EN
    typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    state_t                    state;
    logic [CNT_W-1:0]          beat_cnt;
    logic [DATA_W-1:0]         run_csum;
    logic [DATA_W*BEATS-1:0]   shreg;
    logic                      xfer;

    assign frame_ready = (state == IDLE);
    assign xfer        = valid_a && ready_a;

    // shreg holds only the bytes not yet loaded into data_out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid_a    <= 1'b0;
            last_a     <= 1'b0;
            data_out   <= '0;
            csum_out   <= '0;
            csum_valid <= 1'b0;
            beat_cnt   <= '0;
            run_csum   <= '0;
            shreg      <= '0;
        end else begin
            csum_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (frame_valid) begin
                        shreg    <= frame_data >> DATA_W;
                        data_out <= frame_data[DATA_W-1:0];
                        beat_cnt <= '0;
                        run_csum <= '0;
                        valid_a  <= 1'b1;
                        last_a   <= 1'b0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        run_csum <= run_csum ^ data_out;
                        if (beat_cnt == LAST_BEAT) begin
`ifdef ACCU_TX_CSUM_APPEND_EN
                            data_out <= run_csum ^ data_out;
                            last_a   <= 1'b1;
                            state    <= CSUM;
`else
                            valid_a    <= 1'b0;
                            last_a     <= 1'b0;
                            csum_out   <= run_csum ^ data_out;
                            csum_valid <= 1'b1;
                            state      <= IDLE;
`endif
                        end else begin
                            data_out <= shreg[DATA_W-1:0];
                            shreg    <= shreg >> DATA_W;
                            beat_cnt <= beat_cnt + CNT_W'(1);
`ifndef ACCU_TX_CSUM_APPEND_EN
                            last_a   <= (beat_cnt + CNT_W'(1) == LAST_BEAT);
`endif
                        end
                    end
                end
`ifdef ACCU_TX_CSUM_APPEND_EN
                CSUM: begin
                    if (xfer) begin
                        valid_a    <= 1'b0;
                        last_a     <= 1'b0;
                        csum_out   <= data_out;
                        csum_valid <= 1'b1;
                        state      <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
